// File: rtl/gvt_tracker.sv
// gvt_tracker: scans per-core LVTs and the queue minimum to commit a monotonic GVT and flag the end of simulation
module gvt_tracker #(
  parameter int NUM_CORES = 8,
  parameter int CORE_ID_W = 3,
  parameter int TIME_W    = 14,
  parameter int END_TIME  = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lvt_vld,
  input  logic [CORE_ID_W-1:0] lvt_core,
  input  logic [TIME_W-1:0]    lvt_time,
  input  logic                 qmin_vld,
  input  logic [TIME_W-1:0]    qmin_time,
  output logic [TIME_W-1:0]    gvt,
  output logic                 gvt_vld,
  output logic                 rtn_vld,
  output logic                 err_lvt
);
  typedef enum logic [1:0] {SCAN, COMMIT, DONE} state_t;
  localparam logic [TIME_W-1:0] INF = '1;
  localparam logic [TIME_W-1:0] END_T = TIME_W'(END_TIME);
  localparam logic [CORE_ID_W-1:0] LAST = CORE_ID_W'(NUM_CORES - 1);
  state_t state, state_nxt;
  logic [TIME_W-1:0] lvt [NUM_CORES];
  logic [TIME_W-1:0] acc, rd, qsrc, base, scan_min, cand, nxt_gvt;
  logic [CORE_ID_W-1:0] idx;
  logic [NUM_CORES-1:0] wr, bad;
  logic accept;
  assign accept = lvt_vld && state != DONE;
  assign qsrc = qmin_vld ? qmin_time : INF;
  assign base = idx == '0 ? qsrc : acc;
  assign scan_min = rd < base ? rd : base;
  assign cand = acc < qsrc ? acc : qsrc;
  // an all-infinity round carries no information, so gvt holds
  assign nxt_gvt = cand == INF ? gvt : cand > gvt ? cand : gvt;
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_CORES; i++) rd = idx == CORE_ID_W'(i) ? lvt[i] : rd;
  end
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_ent
    logic hit;
    assign hit = accept && lvt_core == CORE_ID_W'(g);
    assign bad[g] = hit && lvt_time < lvt[g];
    assign wr[g] = hit && lvt_time >= lvt[g];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) lvt[i] <= !rst_n ? '0 : wr[i] ? lvt_time : lvt[i];
  end
  always_ff @(posedge clk) state <= !rst_n ? SCAN : state_nxt;
  always_comb state_nxt = state == SCAN   ? (idx == LAST ? COMMIT : SCAN) :
                          state == COMMIT ? (nxt_gvt >= END_T ? DONE : SCAN) : DONE;
  always_comb rtn_vld = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      acc     <= '0;
      gvt     <= '0;
      gvt_vld <= 1'b0;
      err_lvt <= 1'b0;
    end else begin
      gvt_vld <= state == COMMIT;
      err_lvt <= err_lvt || |bad;
      if (state == SCAN) begin
        acc <= scan_min;
        idx <= idx == LAST ? '0 : idx + CORE_ID_W'(1);
      end
      if (state == COMMIT) gvt <= nxt_gvt;
    end
  end
endmodule
